// File: rtl/aes_128_key_server.sv
// On-the-fly AES-128 round-key generator for a 4-cycle-round AES core.
// Holds the cipher key and produces round keys 1..10, one per key_ready request.
module aes_128_key_server #(
    parameter logic [127:0] KEY_INIT = 128'h0f0e0d0c0b0a09080706050403020100
) (
    input  logic         clk,
    input  logic         kill_n,
    input  logic [127:0] key_in,
    input  logic         key_load,
    input  logic         in_en,
    input  logic         key_ready,
    input  logic         out_en,
    output logic [127:0] key_round,
    output logic [3:0]   round_idx,
    output logic         key_busy,
    output logic         key_err
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    state_t       state;
    logic [127:0] cipher_key;
    logic [127:0] step_base;
    logic [3:0]   step_idx;
    logic [127:0] next_key;

    function automatic logic [7:0] rcon_for(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // One key-schedule step; byte 0 of each word sits in its low byte, so RotWord is a right rotate.
    function automatic logic [127:0] expand_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] rot;
        logic [31:0] temp;
        logic [31:0] n0;
        logic [31:0] n1;
        logic [31:0] n2;
        logic [31:0] n3;
        rot  = {k[103:96], k[127:104]};
        temp = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]} ^ {24'b0, rc};
        n0   = k[31:0]   ^ temp;
        n1   = k[63:32]  ^ n0;
        n2   = k[95:64]  ^ n1;
        n3   = k[127:96] ^ n2;
        return {n3, n2, n1, n0};
    endfunction

    // A restart in the same cycle as a request steps from the round-0 key rather than the current one.
    always_comb begin
        step_base = key_round;
        step_idx  = round_idx;
        if (state == IDLE) begin
            step_base = key_load ? key_in : cipher_key;
            step_idx  = 4'd0;
        end else if (in_en) begin
            step_base = cipher_key;
            step_idx  = 4'd0;
        end
        next_key = expand_step(step_base, rcon_for(step_idx));
    end

    always_ff @(posedge clk or negedge kill_n) begin
        if (!kill_n) begin
            state      <= IDLE;
            cipher_key <= KEY_INIT;
            key_round  <= KEY_INIT;
            round_idx  <= 4'd0;
            key_busy   <= 1'b0;
            key_err    <= 1'b0;
        end else if (out_en) begin
            state     <= IDLE;
            key_round <= cipher_key;
            round_idx <= 4'd0;
            key_busy  <= 1'b0;
            if (key_load) key_err <= 1'b1;
        end else if (state == IDLE) begin
            if (key_load) cipher_key <= key_in;
            if (in_en) begin
                state    <= RUN;
                key_busy <= 1'b1;
            end
            if (in_en && key_ready) begin
                key_round <= next_key;
                round_idx <= 4'd1;
            end else begin
                key_round <= key_load ? key_in : cipher_key;
                round_idx <= 4'd0;
            end
        end else begin
            if (key_load) key_err <= 1'b1;
            if (in_en) begin
                key_round <= key_ready ? next_key : cipher_key;
                round_idx <= key_ready ? 4'd1 : 4'd0;
            end else if (key_ready) begin
                // Asking past round 10 is an overrun: flag it and hold the last key.
                if (round_idx < 4'd10) begin
                    key_round <= next_key;
                    round_idx <= round_idx + 4'd1;
                end else begin
                    key_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/aes_128_key_server.md
# aes_128_key_server

On-the-fly AES-128 round-key generator that serves the `key_ready`/`key_round` request side of the AES-128 4-cycle-round core. It holds the cipher key and presents the round-0 key while idle. It then steps through round keys 1..10, one per `key_ready` request, and returns to the cipher key when the core raises `out_en`. It replaces the stored key table with a single combinational expansion step and registered state.

## Interface
- `KEY_INIT`, default `128'h0f0e0d0c0b0a09080706050403020100`: cipher key loaded at reset.
- `clk`  in  1  clock; all state changes on the rising edge.
- `kill_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `key_in`  in  128  new cipher key, sampled when `key_load`=1.
- `key_load`  in  1  load request for `key_in`.
- `in_en`  in  1  core input strobe; restarts the key sequence.
- `key_ready`  in  1  core request for the next round key.
- `out_en`  in  1  core output strobe; ends the key sequence.
- `key_round`  out  128  current round key to the core (registered).
- `round_idx`  out  4  index of the key on `key_round`, 0..10.
- `key_busy`  out  1  high in RUN.
- `key_err`  out  1  sticky protocol-error flag.

## Operation
- **Byte order:** little-endian; AES byte 0 is in `[7:0]` and byte 15 is in `[127:120]`. Words are w0=`[31:0]` through w3=`[127:96]`.
- **Next-key function** (combinational, from current `key_round` and `round_idx`):
  - temp = SubWord({w3[7:0], w3[31:8]}) ^ {24'b0, rcon}.
  - w0' = w0^temp, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
  - rcon for transitions to idx 1..10 = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
  - SubWord uses 4 combinational forward S-box lookups.
- **Register:** `cipher_key` (128 bits) holds the round-0 key.
- **FSM states:** IDLE and RUN.
- **IDLE:**
  - `key_round`=`cipher_key`, `round_idx`=0.
  - `key_load` → `cipher_key` and `key_round` ← `key_in`.
  - `in_en` → RUN, with `round_idx` held at 0.
  - `key_ready` in IDLE without `in_en` → ignored.
- **RUN:**
  - `key_ready` with `round_idx`<10 → `key_round` ← next key, `round_idx`+1.
  - `key_ready` with `round_idx`=10 → `key_err` set; `key_round` and `round_idx` hold.
  - `in_en` (interleaved-block restart) → `key_round` ← `cipher_key`, `round_idx` ← 0.
  - `out_en` → IDLE, `key_round` ← `cipher_key`, `round_idx` ← 0.
  - `key_load` in RUN → ignored, `key_err` set.
- **Simultaneous events:**
  - `in_en` and `key_ready` together → the restart is applied first, then the step: `key_round` ← round-1 key, `round_idx`=1, state RUN.
  - `out_en` together with any other input → `out_en` wins; `key_load` in the same cycle is ignored and `key_err` is set.
  - `key_load` and `in_en` together in IDLE → load `key_in`; RUN starts on `key_in`.
- **Clearing `key_err`:** only `kill_n`.

## Timing
- **Reset values** (asynchronous on `kill_n`=0): state IDLE, `cipher_key`=`KEY_INIT`, `key_round`=`KEY_INIT`, `round_idx`=0, `key_busy`=0, `key_err`=0.
- **Latency:** `key_ready` sampled high at edge N → the new key is on `key_round` immediately after edge N. This is one-cycle turnaround with no bubbles; back-to-back `key_ready` on every cycle is supported.
- **Full sequence:** 10 round keys need exactly 10 `key_ready` cycles. The core may space requests arbitrarily, e.g. every 4 cycles.
- **`key_busy`:** rises the edge after `in_en` and falls the edge after `out_en`.
- **Reset mid-RUN:** immediate return to IDLE; a key loaded via `key_load` is lost and `KEY_INIT` is restored.
- **Critical path:** one S-box level plus 4 chained 32-bit XORs; this must meet the core clock.

## Test plan
- **Reset state:** assert `kill_n`=0 for 50 ns → `key_round`=`0f0e0d0c0b0a09080706050403020100`, `round_idx`=0, `key_err`=0.
- **Default-key sequence:** `in_en` pulse, then 10 `key_ready` pulses spaced 4 cycles apart →
  - idx1 = `fe76abd6f178a6dafa72afd2fd74aad6`
  - idx2 = `feb3306800c59bbef1bd3d640bcf92b6`
  - idx10 = `c5302b4d8ba707f3174a94e37f1d1113`
  - then `out_en` → `key_round` returns to `0f0e…00` and `key_busy`=0.
- **Loaded-key sequence:** `key_load` with `3c4fcf098815f7aba6d2ae2816157e2b` in IDLE, then run the sequence → idx1 = `05766c2a3939a323b12c548817fefaa0`, idx10 = `a60c63b6c80c3fe18925eec9a8f914d0`.
- **Overrun:** an 11th `key_ready` → `key_err`=1, `key_round` holds the idx10 key, `round_idx`=10.
- **Restart mid-sequence:** `in_en` and `key_ready` in the same cycle at idx5 → `key_round`=`fe76abd6…aad6`, `round_idx`=1.
- **Protocol violations:** `key_load` during RUN → ignored, `key_err`=1, sequence unaffected. `kill_n` asserted mid-RUN → all outputs return to reset values asynchronously.
